// File: rtl/display_scanner_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_scanner_pkg;

  // Inactive levels of the common-anode digit enables and decimal point
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_OFF = 1'b1;

  // One hex digit as presented to the downstream decoder {w,x,y,z}
  typedef logic [3:0] nibble_t;

  // Counter width for a modulus of 'value'; never less than one bit
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Slot prescaler, digit index and blink frame counter for the display scan.
module scan_timer
  import display_scanner_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD        = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [clog2(DIGITS)-1:0]   index,
  output logic                       boundary_c,
  output logic                       in_guard_c,
  output logic                       blink_on
);

  localparam int unsigned PRE_W = clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = clog2(DIGITS);
  localparam int unsigned FRM_W = clog2(BLINK_FRAMES);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0] prescaler;
  logic [FRM_W-1:0] frame_cnt;
  logic             tick;

  assign tick       = (prescaler == PRE_LAST);
  assign boundary_c = tick && (index == IDX_LAST);
  assign in_guard_c = (prescaler < GUARD_END);

  // Advance prescaler and digit index; count frames and flip blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= '0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (tick) begin
        prescaler <= '0;
        index     <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
      if (boundary_c) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed hex scanner for a common-anode seven-segment display.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD        = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output nibble_t               nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = clog2(DIGITS);

  logic [IDX_W-1:0]          index;
  logic                      boundary_c;
  logic                      in_guard_c;
  logic                      blink_on;

  logic [DIGITS-1:0][3:0]    pend_val;
  logic [DIGITS-1:0][3:0]    act_val;
  logic [DIGITS-1:0]         pend_dp;
  logic [DIGITS-1:0]         act_dp;
  logic                      pend_flag;

  logic [DIGITS-1:0]         lz_c;
  logic                      all_zero_c;
  nibble_t                   nibble_nxt;
  logic [DIGITS-1:0]         an_nxt;
  logic                      dp_nxt;

  scan_timer #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (index),
    .boundary_c (boundary_c),
    .in_guard_c (in_guard_c),
    .blink_on   (blink_on)
  );

  // Double-buffer the displayed value so it only changes at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
    end else if (boundary_c) begin
      pend_flag <= 1'b0;
      if (load) begin
        act_val <= data_in;
        act_dp  <= dp_in;
      end else if (pend_flag) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
    end else if (load) begin
      pend_val  <= data_in;
      pend_dp   <= dp_in;
      pend_flag <= 1'b1;
    end
  end

  // Digit i is a leading zero when it and every higher digit are zero
  always_comb begin
    lz_c       = '0;
    all_zero_c = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero_c = all_zero_c && (act_val[i] == 4'h0);
      lz_c[i]    = blank_lz && all_zero_c;
    end
  end

  // Select next outputs for the current slot; nibble leads the anode by the guard
  always_comb begin
    nibble_nxt = act_val[index];
    an_nxt     = {DIGITS{AN_OFF}};
    dp_nxt     = DP_OFF;
    if (!in_guard_c && !(blink_en && !blink_on)) begin
      if (!lz_c[index]) begin
        an_nxt[index] = ~AN_OFF;
      end
      dp_nxt = ~act_dp[index];
    end
  end

  // Register all display outputs and the end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibble     <= '0;
      an         <= {DIGITS{AN_OFF}};
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      nibble     <= nibble_nxt;
      an         <= an_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary_c;
    end
  end

endmodule
